// File: rtl/sparhixcel_pkg.sv
// Shared weight-path definitions: array geometry, weight-memory address width
// and the weight writer state encoding, so writer and memory cannot disagree.
package sparhixcel_pkg;

    localparam int SPX_N_ROWS_ARRAY    = 16;
    localparam int SPX_F_WIDTH         = 8;
    localparam int SPX_WMEM_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wmw_state_e;

    // A new load may only be started from a quiescent state.
    function automatic logic can_start(input wmw_state_e st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/weight_mem_writer_if.sv
// Byte stream (valid/ready) plus weight-memory mem2 write port of the weight writer.
interface weight_mem_writer_if
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY = SPX_N_ROWS_ARRAY,
    parameter int F_WIDTH      = SPX_F_WIDTH,
    parameter int ADDR_WIDTH   = SPX_WMEM_ADDR_WIDTH
) ();

    logic [F_WIDTH-1:0]              s_data_i;
    logic                            s_valid_i;
    logic                            s_ready_o;
    logic                            wr_mem2_ld_o;
    logic [ADDR_WIDTH-1:0]           wr_addrs_mem2_o;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0] mem2_data_o;

    modport slave (
        input  s_data_i, s_valid_i,
        output s_ready_o, wr_mem2_ld_o, wr_addrs_mem2_o, mem2_data_o
    );

    modport master (
        output s_data_i, s_valid_i,
        input  s_ready_o, wr_mem2_ld_o, wr_addrs_mem2_o, mem2_data_o
    );

endinterface

// File: rtl/weight_mem_writer_lane_packer.sv
// weight_lane_packer: gathers N_ROWS_ARRAY stream bytes into one word; word_o
// holds the last complete word, word_full_o flags the beat that completes it.
module weight_lane_packer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY = SPX_N_ROWS_ARRAY,
    parameter int F_WIDTH      = SPX_F_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rd_weight_rst,
    input  logic                            clr_i,
    input  logic                            beat_i,
    input  logic [F_WIDTH-1:0]              data_i,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0] word_o,
    output logic                            word_full_o
);

    localparam int CNT_W = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N_ROWS_ARRAY - 1);

    logic [CNT_W-1:0]                lane_cnt_r;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0] lanes_r;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0] lanes_next_s;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0] word_r;
    logic                            full_s;

    // Lane image including the byte arriving this cycle.
    always_comb begin
        lanes_next_s = lanes_r;
        if (beat_i) begin
            lanes_next_s[int'(lane_cnt_r) * F_WIDTH +: F_WIDTH] = data_i;
        end else begin
            lanes_next_s = lanes_r;
        end
    end

    assign full_s      = beat_i && (lane_cnt_r == LAST_LANE);
    assign word_full_o = full_s;
    assign word_o      = word_r;

    // Lane storage and counter; the completed word is latched so it stays
    // stable through the write strobe and between writes.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            lane_cnt_r <= '0;
            lanes_r    <= '0;
            word_r     <= '0;
        end else if (clr_i) begin
            lane_cnt_r <= '0;
            lanes_r    <= '0;
        end else if (beat_i) begin
            lanes_r    <= lanes_next_s;
            lane_cnt_r <= full_s ? '0 : lane_cnt_r + CNT_W'(1'b1);
            if (full_s) begin
                word_r <= lanes_next_s;
            end
        end
    end

endmodule

// File: rtl/weight_mem_writer.sv
// Weight-memory producer: packs the byte stream into words and writes them to
// mem2 at auto-incrementing addresses. Optional checksum: WEIGHT_CHECKSUM_EN.
module weight_mem_writer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY = SPX_N_ROWS_ARRAY,
    parameter int F_WIDTH      = SPX_F_WIDTH,
    parameter int ADDR_WIDTH   = SPX_WMEM_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rd_weight_rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] num_words_i,
    weight_mem_writer_if.slave    bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  weight_ready_o
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic [15:0]           checksum_o
`endif
);

    wmw_state_e            state_r;
    wmw_state_e            next_state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] word_cnt_r;
    logic [ADDR_WIDTH-1:0] num_r;
    logic                  done_r;
    logic                  ready_r;
    logic                  start_acc_s;
    logic                  last_word_s;
    logic                  beat_s;
    logic                  word_full_s;
    logic                  s_ready_s;
    logic                  ld_s;
    logic                  busy_s;

    assign start_acc_s = start_i && can_start(state_r);
    assign last_word_s = (word_cnt_r + ADDR_WIDTH'(1'b1)) == num_r;
    assign beat_s      = bus.s_valid_i && s_ready_s;

    weight_lane_packer #(
        .N_ROWS_ARRAY (N_ROWS_ARRAY),
        .F_WIDTH      (F_WIDTH)
    ) u_packer (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .clr_i         (start_acc_s),
        .beat_i        (beat_s),
        .data_i        (bus.s_data_i),
        .word_o        (bus.mem2_data_o),
        .word_full_o   (word_full_s)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a zero-length request goes straight to DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    next_state_s = (num_words_i == '0) ? ST_DONE : ST_PACK;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_PACK: begin
                if (word_full_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_PACK;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_PACK;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        s_ready_s = 1'b0;
        ld_s      = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            ST_PACK: begin
                s_ready_s = 1'b1;
                busy_s    = 1'b1;
            end
            ST_WRITE: begin
                ld_s   = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                s_ready_s = 1'b0;
                ld_s      = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Load parameters, address and word count; done is a pulse on each entry
    // into DONE, including a zero-length restart from DONE.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            addr_r     <= '0;
            word_cnt_r <= '0;
            num_r      <= '0;
            done_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            if (start_acc_s) begin
                addr_r     <= base_addr_i;
                num_r      <= num_words_i;
                word_cnt_r <= '0;
            end else if (state_r == ST_WRITE) begin
                addr_r     <= addr_r + ADDR_WIDTH'(1'b1);
                word_cnt_r <= word_cnt_r + ADDR_WIDTH'(1'b1);
            end
            ready_r <= (next_state_s == ST_DONE);
            done_r  <= (next_state_s == ST_DONE) && ((state_r != ST_DONE) || start_acc_s);
        end
    end

    assign bus.s_ready_o       = s_ready_s;
    assign bus.wr_mem2_ld_o    = ld_s;
    assign bus.wr_addrs_mem2_o = addr_r;
    assign busy_o              = busy_s;
    assign done_o              = done_r;
    assign weight_ready_o      = ready_r;

`ifdef WEIGHT_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running sum of accepted bytes since the last accepted start.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            checksum_r <= 16'h0000;
        end else if (start_acc_s) begin
            checksum_r <= 16'h0000;
        end else if (beat_s) begin
            checksum_r <= checksum_r + 16'(bus.s_data_i);
        end
    end

    assign checksum_o = checksum_r;
`endif

endmodule

// File: tb/tb_weight_mem_writer.sv
// Bench for weight_mem_writer: table of loads plus random loads, checked
// against an array-based model of the expected write list.
module tb_weight_mem_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic [15:0]  base_addr_i = 16'h0000;
    logic [15:0]  num_words_i = 16'h0000;
    logic         busy_o, done_o, weight_ready_o;
`ifdef WEIGHT_CHECKSUM_EN
    logic [15:0]  checksum_o;
`endif

    weight_mem_writer_if wif ();

    weight_mem_writer dut (
        .clk_i          (clk),
        .rd_weight_rst  (rst),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .num_words_i    (num_words_i),
        .bus            (wif),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .weight_ready_o (weight_ready_o)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .checksum_o     (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_beat_cyc = 0;

    logic [15:0]  wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    int           wr_cyc_q[$];
    logic [7:0]   stream_q[$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          pct;
        int          mode;      // 0 random, 1 incrementing from 1, 2 all 0xFF
        bit          poke;      // pulse start_i in the middle of PACK
        logic [15:0] exp_final_addr;
        int          exp_writes;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor.
    always @(negedge clk) begin
        if (wif.wr_mem2_ld_o) begin
            wr_addr_q.push_back(wif.wr_addrs_mem2_o);
            wr_data_q.push_back(wif.mem2_data_o);
            wr_cyc_q.push_back(cyc);
            check("ready_low_in_write", {127'd0, wif.s_ready_o}, 128'd0);
        end
        if (done_o) done_cnt++;
    end

    task automatic run_load(input vec_t v);
        int          idx;
        int          budget;
        int          nbytes;
        bit          poked;
        logic [7:0]  b;
        logic [127:0] exp_word;
        logic [15:0] exp_addr;
        logic [15:0] sum;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); stream_q.delete();
        done_cnt = 0;
        nbytes = int'(v.num) * 16;
        for (int i = 0; i < nbytes; i++) begin
            case (v.mode)
                1:       b = 8'(i + 1);
                2:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            stream_q.push_back(b);
        end
        @(negedge clk);
        start_i = 1'b1; base_addr_i = v.base; num_words_i = v.num;
        @(negedge clk);
        start_i = 1'b0; base_addr_i = 16'($urandom); num_words_i = 16'($urandom);
        if (v.num == 16'd0) begin
            check("zero_len_done", {127'd0, done_o}, 128'd1);
            check("zero_len_no_write", {127'd0, wif.wr_mem2_ld_o}, 128'd0);
        end else begin
            check("ready_cleared_on_start", {127'd0, weight_ready_o}, 128'd0);
            check("busy_after_start", {127'd0, busy_o}, 128'd1);
        end
        idx = 0; budget = 0; poked = 1'b0;
        while (idx < nbytes && budget < 3000) begin
            if ($urandom_range(99) < v.pct) begin
                wif.s_valid_i = 1'b1; wif.s_data_i = stream_q[idx];
            end else begin
                wif.s_valid_i = 1'b0; wif.s_data_i = 8'($urandom);
            end
            if (v.poke && !poked && idx == 5 && wif.s_ready_o) begin
                start_i = 1'b1; base_addr_i = 16'hAAAA; num_words_i = 16'd7; poked = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (wif.s_valid_i && wif.s_ready_o) begin
                idx++;
                last_beat_cyc = cyc;
            end
            @(negedge clk);
            budget++;
        end
        wif.s_valid_i = 1'b0; start_i = 1'b0;
        budget = 0;
        while (!weight_ready_o && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("load_completes_in_time", {127'd0, weight_ready_o}, 128'd1);
        @(negedge clk);
        check("done_pulse_count", 128'(done_cnt), 128'd1);
        check("ready_held", {127'd0, weight_ready_o}, 128'd1);
        check("idle_not_busy", {127'd0, busy_o}, 128'd0);
        check("write_count", 128'(wr_addr_q.size()), 128'(v.exp_writes));
        check("final_addr_reg", 128'(wif.wr_addrs_mem2_o), 128'(v.exp_final_addr));
        // Reference: word w is bytes 16w..16w+15 with lane 0 in the low byte.
        for (int w = 0; w < int'(v.num) && w < wr_addr_q.size(); w++) begin
            exp_addr = v.base + 16'(w);
            exp_word = '0;
            for (int k = 0; k < 16; k++) exp_word[k*8 +: 8] = stream_q[w*16 + k];
            check("write_addr", 128'(wr_addr_q[w]), 128'(exp_addr));
            check("write_data", wr_data_q[w], exp_word);
            if (w == int'(v.num) - 1) begin
                check("data_held_after_write", wif.mem2_data_o, exp_word);
                check("write_latency", 128'(wr_cyc_q[w]), 128'(last_beat_cyc + 1));
            end
        end
        sum = 16'h0000;
        foreach (stream_q[i]) sum = sum + 16'(stream_q[i]);
`ifdef WEIGHT_CHECKSUM_EN
        check("checksum", 128'(checksum_o), 128'(sum));
        if (v.mode == 2) check("checksum_ff", 128'(checksum_o), 128'h0FF0);
`endif
        if (v.mode == 2 && v.num == 16'd1) check("model_sum_ff", 128'(sum), 128'h0FF0);
    endtask

    initial begin
        vec_t rv;
        wif.s_valid_i = 1'b0;
        wif.s_data_i  = 8'h00;
        vecs[0] = '{16'h0010, 16'd1, 100, 1, 1'b0, 16'h0011, 1};
        vecs[1] = '{16'h0100, 16'd3,  60, 0, 1'b0, 16'h0103, 3};
        vecs[2] = '{16'h1234, 16'd0, 100, 0, 1'b0, 16'h1234, 0};
        vecs[3] = '{16'hFFFF, 16'd2, 100, 0, 1'b0, 16'h0001, 2};
        vecs[4] = '{16'h0040, 16'd1, 100, 2, 1'b1, 16'h0041, 1};
        vecs[5] = '{16'h0200, 16'd2,  30, 0, 1'b0, 16'h0202, 2};

        #1 rst = 1'b1;
        #2;
        check("rst_ld", {127'd0, wif.wr_mem2_ld_o}, 128'd0);
        check("rst_ready", {127'd0, wif.s_ready_o}, 128'd0);
        check("rst_addr", 128'(wif.wr_addrs_mem2_o), 128'd0);
        check("rst_data", wif.mem2_data_o, 128'd0);
        check("rst_flags", {125'd0, busy_o, done_o, weight_ready_o}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i]);
            if (i == 0) check("single_word_const", wr_data_q.size() > 0 ? wr_data_q[0] : 128'd0,
                              128'h100F0E0D0C0B0A090807060504030201);
        end

        // Reset after 7 accepted beats discards the partial word.
        wr_addr_q.delete();
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 16'h0300; num_words_i = 16'd1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wif.s_valid_i = 1'b1; wif.s_data_i = 8'h55;
            @(negedge clk);
        end
        wif.s_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ld", {127'd0, wif.wr_mem2_ld_o}, 128'd0);
        check("midrst_s_ready", {127'd0, wif.s_ready_o}, 128'd0);
        check("midrst_addr", 128'(wif.wr_addrs_mem2_o), 128'd0);
        check("midrst_data", wif.mem2_data_o, 128'd0);
        check("midrst_flags", {125'd0, busy_o, done_o, weight_ready_o}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_write", 128'(wr_addr_q.size()), 128'd0);
        run_load(vecs[0]);

        // Randomized loads.
        for (int i = 0; i < 4; i++) begin
            rv.base = 16'($urandom);
            rv.num  = 16'($urandom_range(3, 1));
            rv.pct  = int'($urandom_range(100, 40));
            rv.mode = 0;
            rv.poke = 1'b0;
            rv.exp_final_addr = rv.base + rv.num;
            rv.exp_writes = int'(rv.num);
            run_load(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_mem_writer.md
Name: weight_mem_writer

Overview:
- Producer side of the weight-memory interface.
- Accepts a byte-serial weight stream over a valid/ready handshake and packs N_ROWS_ARRAY lanes into one weight word.
- Writes each word into the weight memory through the mem2 write port (data, address, write strobe), with auto-incrementing addresses from a base.
- Raises weight_ready_o when the requested block is fully loaded; this is the level the SA controller samples as weight_ready_i.

Parameters:
- N_ROWS_ARRAY, 16, number of lanes per weight word (one per array row)
- F_WIDTH, 8, bits per weight
- ADDR_WIDTH, 16, weight-memory address width

Ports:
- clk_i  in  1  clock
- rd_weight_rst  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a load; sampled only in IDLE or DONE
- base_addr_i  in  ADDR_WIDTH  first write address, captured on start
- num_words_i  in  ADDR_WIDTH  words to write, captured on start; 0 is legal
- s_data_i  in  F_WIDTH  stream weight byte
- s_valid_i  in  1  stream data valid
- s_ready_o  out  1  stream ready
- wr_mem2_ld_o  out  1  weight-memory write strobe
- wr_addrs_mem2_o  out  ADDR_WIDTH  write address
- mem2_data_o  out  N_ROWS_ARRAY*F_WIDTH  packed word; lane k occupies bits [(k+1)*F_WIDTH-1 : k*F_WIDTH]
- busy_o  out  1  high in PACK or WRITE
- done_o  out  1  one-cycle pulse on entry to DONE
- weight_ready_o  out  1  level: block loaded

Behaviour:
- Reset: asynchronous, active-high on rd_weight_rst, clock clk_i. While asserted, all outputs are 0, state is IDLE, and the lane counter, word counter and address register are 0.
- States: IDLE, PACK, WRITE, DONE.
- IDLE/DONE with start_i=1:
  - Capture base_addr_i and num_words_i.
  - Clear the word counter and lane counter; clear weight_ready_o.
  - If num_words_i==0, go to DONE next cycle (done_o pulses, weight_ready_o set). Otherwise go to PACK.
- start_i in PACK or WRITE: ignored, no effect.
- PACK:
  - s_ready_o=1 combinationally in PACK only.
  - A beat transfers when s_valid_i & s_ready_o. The byte is stored in lane[lane_cnt], then lane_cnt increments.
  - The beat that fills lane N_ROWS_ARRAY-1 moves the FSM to WRITE and resets lane_cnt to 0.
  - s_valid_i low: hold state, no lane change.
- WRITE (exactly one cycle):
  - wr_mem2_ld_o=1; wr_addrs_mem2_o = current address; mem2_data_o = packed word (registered, stable during the strobe).
  - Next cycle: address += 1, wrapping modulo 2^ADDR_WIDTH; word counter += 1.
  - If word counter + 1 == num_words, go to DONE, else go to PACK.
  - s_ready_o=0 during WRITE.
- Latency and throughput:
  - wr_mem2_ld_o asserts the cycle after the last lane beat is accepted.
  - Peak throughput is one word per N_ROWS_ARRAY+1 cycles.
- DONE:
  - done_o=1 for the entry cycle only; weight_ready_o=1 and held until the next accepted start_i or reset.
  - A new start_i in DONE behaves as in IDLE.
- mem2_data_o: holds the last written word between writes. A partially filled word is never written.
- Reset mid-operation: the partial word is discarded, no write is issued, weight_ready_o=0, and the block returns to IDLE.
- Address outputs are valid only when wr_mem2_ld_o=1; wr_addrs_mem2_o otherwise holds the current address register.

Optional Feature:
- Macro: WEIGHT_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o (16 bits): the sum modulo 2^16 of all accepted bytes, bytes zero-extended.
  - Cleared on an accepted start_i and on reset; valid when weight_ready_o=1.
  - Lets software compare against a host-side sum.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Shared package sparhixcel_pkg holds:
  - the state enum typedef (IDLE, PACK, WRITE, DONE);
  - the N_ROWS_ARRAY, F_WIDTH and weight-memory address-width constants, so this block and the top-level weight memory cannot disagree.
- One natural sub-module, weight_lane_packer:
  - lane counter plus N_ROWS_ARRAY x F_WIDTH lane registers;
  - outputs the packed word and a word_full pulse.
- The FSM, counters and address register stay in weight_mem_writer.

Test Plan:
- Single word, N_ROWS_ARRAY=16: start with base=0x0010, num_words=1, stream bytes 0x01..0x10 with valid held high -> one wr_mem2_ld_o pulse at addr 0x0010, data 0x100F...0201 (lane0=0x01), one cycle after the 16th beat; done_o pulse; weight_ready_o=1.
- Three words with random s_valid_i gaps: base=0x0100, num=3 -> writes at 0x0100, 0x0101, 0x0102 only; s_ready_o=0 in every WRITE cycle; no byte lost or duplicated.
- Zero-length load: num_words=0 -> DONE the cycle after start, no write strobe, done_o pulse, weight_ready_o=1.
- Address wrap: base=0xFFFF, num=2 -> writes at 0xFFFF then 0x0000.
- Reset mid-operation: assert rd_weight_rst after 7 beats -> all outputs 0 immediately, no write; a following full load writes a correct fresh word.
- With WEIGHT_CHECKSUM_EN: 16 bytes of 0xFF -> checksum_o=0x0FF0; start_i pulsed during PACK is ignored.
